// File: rtl/seg_scan_scheduler.sv
// Two-digit 7-segment scan controller: digit 0 = record clip, digit 1 = play clip, with activity blink.
// Define SEG_GUARD_EN to insert a one-cycle all-anodes-off guard slot between digits.
module seg_scan_scheduler #(
  parameter int DWELL_CYCLES = 100000,
  parameter int BLINK_FRAMES = 250
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       switch0,
  input  logic       switch1,
  input  logic       recording,
  input  logic       playing,
  output logic       a0,
  output logic       a1,
  output logic [6:0] cathode
);
  localparam int DW = $clog2(DWELL_CYCLES);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [6:0] GLYPH_CLIP1 = 7'h4F;
  localparam logic [6:0] GLYPH_CLIP2 = 7'h12;
  localparam logic [6:0] GLYPH_BLANK = 7'h7F;

  typedef enum logic [2:0] {S_IDLE, S_D0, S_G0, S_D1, S_G1} state_t;

  state_t        state;
  logic [DW-1:0] dwell_cnt;
  logic [FW-1:0] frame_cnt;
  logic          blink_phase;
  logic [1:0]    sync0, sync1;
  logic          dwell_done, frame_wrap, phase_next;
  logic [6:0]    glyph0_first, glyph0_next, glyph1;

  function automatic logic [6:0] glyph(input logic sel, input logic blank);
    if (blank) return GLYPH_BLANK;
    return sel ? GLYPH_CLIP2 : GLYPH_CLIP1;
  endfunction

  assign dwell_done   = (dwell_cnt == DW'(DWELL_CYCLES - 1));
  assign frame_wrap   = (frame_cnt == FW'(BLINK_FRAMES - 1));
  assign phase_next   = frame_wrap ? ~blink_phase : blink_phase;
  assign glyph0_first = glyph(sync0[1], recording & ~blink_phase);
  // A new frame's digit-0 glyph must already see the phase that frame runs in.
  assign glyph0_next  = glyph(sync0[1], recording & ~phase_next);
  assign glyph1       = glyph(sync1[1], playing & ~blink_phase);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      dwell_cnt   <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b1;
      sync0       <= '0;
      sync1       <= '0;
      a0          <= 1'b1;
      a1          <= 1'b1;
      cathode     <= GLYPH_BLANK;
    end else begin
      sync0 <= {sync0[0], switch0};
      sync1 <= {sync1[0], switch1};
      case (state)
        S_IDLE: begin
          state   <= S_D0;
          a0      <= 1'b0;
          a1      <= 1'b1;
          cathode <= glyph0_first;
        end
        S_D0: begin
          if (dwell_done) begin
            dwell_cnt <= '0;
            a0        <= 1'b1;
`ifdef SEG_GUARD_EN
            state     <= S_G0;
`else
            state     <= S_D1;
            a1        <= 1'b0;
            cathode   <= glyph1;
`endif
          end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
          end
        end
`ifdef SEG_GUARD_EN
        S_G0: begin
          state   <= S_D1;
          a1      <= 1'b0;
          cathode <= glyph1;
        end
        S_D1: begin
          if (dwell_done) begin
            dwell_cnt <= '0;
            a1        <= 1'b1;
            state     <= S_G1;
          end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
          end
        end
        S_G1: begin
          state       <= S_D0;
          a0          <= 1'b0;
          cathode     <= glyph0_next;
          frame_cnt   <= frame_wrap ? '0 : frame_cnt + 1'b1;
          blink_phase <= phase_next;
        end
`else
        S_D1: begin
          if (dwell_done) begin
            dwell_cnt   <= '0;
            a1          <= 1'b1;
            a0          <= 1'b0;
            state       <= S_D0;
            cathode     <= glyph0_next;
            frame_cnt   <= frame_wrap ? '0 : frame_cnt + 1'b1;
            blink_phase <= phase_next;
          end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
          end
        end
`endif
        default: begin
          state     <= S_IDLE;
          dwell_cnt <= '0;
          a0        <= 1'b1;
          a1        <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Scoreboard bench for seg_scan_scheduler (DWELL_CYCLES=4, BLINK_FRAMES=2), guard on or off.
module tb_seg_scan_scheduler;
  localparam int D = 4;
`ifdef SEG_GUARD_EN
  localparam int G = 1;
`else
  localparam int G = 0;
`endif
  localparam int F = 2*D + 2*G;

  typedef struct {
    int         start;
    int         digit;
    logic [6:0] glyph;
  } exp_t;

  typedef struct packed {
    logic       sw0;
    logic       sw1;
    logic       rec;
    logic       ply;
    logic [6:0] g0;
    logic [6:0] g1;
  } row_t;

  // Per-frame inputs and hand-computed glyphs; blink is blank in frames where (f/2) is odd.
  row_t seg_a [16] = '{
    '{1'b0, 1'b0, 1'b0, 1'b0, 7'h4F, 7'h4F},
    '{1'b1, 1'b0, 1'b0, 1'b0, 7'h12, 7'h4F},
    '{1'b1, 1'b1, 1'b0, 1'b0, 7'h12, 7'h12},
    '{1'b1, 1'b1, 1'b1, 1'b0, 7'h7F, 7'h12},
    '{1'b1, 1'b1, 1'b1, 1'b0, 7'h12, 7'h12},
    '{1'b1, 1'b1, 1'b1, 1'b0, 7'h12, 7'h12},
    '{1'b1, 1'b1, 1'b1, 1'b0, 7'h7F, 7'h12},
    '{1'b1, 1'b1, 1'b1, 1'b1, 7'h7F, 7'h7F},
    '{1'b1, 1'b1, 1'b1, 1'b1, 7'h12, 7'h12},
    '{1'b1, 1'b1, 1'b1, 1'b1, 7'h12, 7'h12},
    '{1'b1, 1'b1, 1'b1, 1'b1, 7'h7F, 7'h7F},
    '{1'b1, 1'b1, 1'b0, 1'b0, 7'h12, 7'h12},
    '{1'b0, 1'b0, 1'b0, 1'b0, 7'h4F, 7'h4F},
    '{1'b0, 1'b1, 1'b0, 1'b1, 7'h4F, 7'h12},
    '{1'b0, 1'b1, 1'b0, 1'b1, 7'h4F, 7'h7F},
    '{1'b0, 1'b1, 1'b0, 1'b1, 7'h4F, 7'h7F}
  };
  row_t seg_b [4] = '{
    '{1'b0, 1'b1, 1'b0, 1'b1, 7'h4F, 7'h12},
    '{1'b0, 1'b1, 1'b0, 1'b1, 7'h4F, 7'h12},
    '{1'b0, 1'b1, 1'b0, 1'b1, 7'h4F, 7'h7F},
    '{1'b0, 1'b1, 1'b0, 1'b1, 7'h4F, 7'h7F}
  };

  logic       clock, reset, switch0, switch1, recording, playing;
  logic       a0, a1;
  logic [6:0] cathode;
  int         total, bad, cyc;
  exp_t       q[$];

  seg_scan_scheduler #(.DWELL_CYCLES(D), .BLINK_FRAMES(2)) dut (
    .clock(clock), .reset(reset), .switch0(switch0), .switch1(switch1),
    .recording(recording), .playing(playing),
    .a0(a0), .a1(a1), .cathode(cathode)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Edges since reset release; the first D0 dwell starts on edge 1.
  always @(posedge clock or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at cyc=%0d", name, act, req, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    int budget;
    budget = 1000;
    while (cyc < n && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    chk("wait_cyc_timeout", int'(cyc >= n), 1);
  endtask

  task automatic apply_row(input row_t r, input int f);
    exp_t e;
    switch0   = r.sw0;
    switch1   = r.sw1;
    recording = r.rec;
    playing   = r.ply;
    e.start = 1 + f*F;         e.digit = 0; e.glyph = r.g0; q.push_back(e);
    e.start = 1 + f*F + D + G; e.digit = 1; e.glyph = r.g1; q.push_back(e);
  endtask

  // Monitor: every dwell start pops one expectation; lengths and gaps checked as runs end.
  initial begin
    int         run, cur, run_len, gap;
    bit         skip_gap;
    logic [6:0] held;
    exp_t       e;
    run = 2; run_len = 0; gap = 0; skip_gap = 1; held = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        run = 2; run_len = 0; gap = 0; skip_gap = 1;
      end else begin
        chk("anode_exclusive", int'(!(a0 == 1'b0 && a1 == 1'b0)), 1);
        cur = !a0 ? 0 : (!a1 ? 1 : 2);
        if (cur != run) begin
          if (run != 2) chk("dwell_len", run_len, D);
          if (cur != 2) begin
            if (!skip_gap) chk("guard_len", gap, G);
            if (q.size() == 0) begin
              total++; bad++;
              $display("FAIL unexpected_dwell actual=digit%0d required=none at cyc=%0d", cur, cyc);
            end else begin
              e = q.pop_front();
              chk("dwell_start", cyc, e.start);
              chk("dwell_digit", cur, e.digit);
              chk("dwell_glyph", int'(cathode), int'(e.glyph));
            end
            held = cathode; skip_gap = 0; gap = 0;
          end
          run = cur; run_len = 0;
        end
        if (cur == 2) gap++;
        else begin
          run_len++;
          chk("glyph_hold", int'(cathode), int'(held));
        end
      end
    end
  end

  initial begin
    total = 0; bad = 0;
    reset = 1'b0; switch0 = 1'b0; switch1 = 1'b0; recording = 1'b0; playing = 1'b0;
    #23;
    chk("rst_a0", int'(a0), 1);
    chk("rst_a1", int'(a1), 1);
    chk("rst_cathode", int'(cathode), 'h7F);
    apply_row(seg_a[0], 0);
    @(negedge clock); #2 reset = 1'b1;
    for (int f = 1; f < 16; f++) begin
      wait_cyc(1 + (f-1)*F + D + G + 1);
      apply_row(seg_a[f], f);
    end
    // Asynchronous reset in the middle of frame 15's D1 dwell (blank phase).
    wait_cyc(1 + 15*F + D + G + 1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_a0", int'(a0), 1);
    chk("midrst_a1", int'(a1), 1);
    chk("midrst_cathode", int'(cathode), 'h7F);
    chk("queue_empty_a", q.size(), 0);
    @(negedge clock);
    chk("rst_hold_a1", int'(a1), 1);
    apply_row(seg_b[0], 0);
    @(negedge clock); #2 reset = 1'b1;
    for (int f = 1; f < 4; f++) begin
      wait_cyc(1 + (f-1)*F + D + G + 1);
      apply_row(seg_b[f], f);
    end
    wait_cyc(1 + 3*F + 2*D + G - 1);
    chk("queue_empty_b", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seg_scan_scheduler.md
Name: seg_scan_scheduler

Overview:
- Time-multiplexed scan controller for the two-digit 7-segment display on the clip recorder board.
- Digit 0 (anode a0) shows the record-clip number selected by switch0; digit 1 (anode a1) shows the play-clip number selected by switch1.
- Blinks the active digit while the recorder is recording or playing.
- Sits between the top-level switch/status signals and the board anode/cathode pins, and owns the display refresh schedule.

Parameters:
- DWELL_CYCLES, 100000, clock cycles each digit is driven per scan slot; must be >= 2.
- BLINK_FRAMES, 250, completed scan frames per blink half-period; must be >= 1.

Ports:
- clock  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- switch0  input  1  record clip select, asynchronous (0 = clip 1, 1 = clip 2)
- switch1  input  1  play clip select, asynchronous (0 = clip 1, 1 = clip 2)
- recording  input  1  synchronous status from record controller
- playing  input  1  synchronous status from playback controller
- a0  output  1  digit 0 anode, active-low
- a1  output  1  digit 1 anode, active-low
- cathode  output  7  segments, active-low; cathode[6] = a … cathode[0] = g

Behaviour:
- Reset (reset low, asynchronous) values:
  - a0 = a1 = 1
  - cathode = 7'h7F
  - FSM in S_IDLE
  - dwell counter = 0, frame counter = 0
  - blink_phase = 1 (visible)
  - synchronizers = 0
- Mid-operation reset takes effect immediately, without waiting for a clock edge.
- Switch synchronization: switch0 and switch1 pass through 2-flop synchronizers. A switch change reaches the latched digit value at the next dwell start, never mid-dwell.
- Glyphs:
  - clip 1 = 7'h4F
  - clip 2 = 7'h12
  - blank = 7'h7F
- FSM states: S_IDLE, S_D0, S_G0, S_D1, S_G1.
  - S_IDLE → S_D0 on the first clock after reset deassertion.
  - S_D0: a0 = 0, a1 = 1, cathode = latched digit-0 glyph. Held DWELL_CYCLES cycles, then → S_G0.
  - S_G0: a0 = a1 = 1 for 1 cycle, then → S_D1.
  - S_D1: a1 = 0, a0 = 1, cathode = latched digit-1 glyph. Held DWELL_CYCLES cycles, then → S_G1.
  - S_G1: a0 = a1 = 1 for 1 cycle, then → S_D0.
- Dwell counter:
  - Width $clog2(DWELL_CYCLES).
  - Counts 0..DWELL_CYCLES-1 within each Dx state and wraps to 0 on exit.
  - Held at 0 in guard states.
- Glyph latching: glyph values are computed and registered on the cycle entering Dx. Cathode is constant for the whole dwell.
- Anode exclusivity: a0 and a1 are never both 0 in any cycle, including across transitions.
- Blink:
  - The frame counter increments on each S_G1 → S_D0 transition.
  - At BLINK_FRAMES-1 the frame counter wraps to 0 and blink_phase toggles.
  - Digit 0 is blank when recording = 1 and blink_phase = 0.
  - Digit 1 is blank when playing = 1 and blink_phase = 0.
  - recording and playing are sampled at dwell start, with the glyph.
- Simultaneous recording and playing: both digits blink in the same phase; no priority.
- Status deassertion: if recording or playing deasserts while blink_phase = 0, the digit is visible from its next dwell start. blink_phase keeps free-running.
- Frame length: 2*DWELL_CYCLES + 2 cycles with guard, 2*DWELL_CYCLES without.

Optional Feature:
- SEG_GUARD_EN:
  - Defined: S_G0 and S_G1 are present; one blanking cycle (both anodes off) separates digits to suppress ghosting.
  - Undefined: S_G0 and S_G1 are removed; S_D0 → S_D1 → S_D0 directly. The anode switch and the new cathode value change on the same edge.
  - The blink frame counter then increments on the S_D1 → S_D0 transition.

Test Plan (DWELL_CYCLES = 4, BLINK_FRAMES = 2):
- Reset, then release with switch0 = 0, switch1 = 0 → cycle 1: a0 = 0, a1 = 1, cathode = 4F for 4 cycles; guard a0 = a1 = 1 for 1 cycle; then a1 = 0, cathode = 4F for 4 cycles; frame period 10 cycles.
- Set switch0 = 1 mid-D0 dwell → current dwell remains 4F; the first D0 dwell starting ≥ 2 cycles after the change shows 12. Set switch1 = 1 → D1 shows 12 likewise.
- recording = 1, playing = 0 → D0 alternates visible for 2 frames, blank (7F) for 2 frames (20-cycle half-period); D1 always shows its glyph.
- recording = 1 and playing = 1 → D0 and D1 are blanked in the same frames; deassert both during a blank phase → next dwells are visible.
- Assert reset low mid-S_D1 (asynchronously, between edges) → a0 = a1 = 1 and cathode = 7F immediately; after release, the sequence restarts at S_D0 with blink_phase = 1.
- Every cycle, assert !(a0 == 0 && a1 == 0). Build with SEG_GUARD_EN undefined → frame period 8 cycles, no blank cycles.
